// File: rtl/cntr_bs_arbiter.sv
// Bank scheduler arbiter: dequeues one read or write FIFO head per cycle using
// read/write batching with turnaround, capped row-hit-first, round-robin and starvation guards.
module cntr_bs_arbiter #(
    parameter  int RD_FIFO_NUM = 4,
    parameter  int WR_FIFO_NUM = 3,
    parameter  int RA          = 16,
    parameter  int CA          = 10,
    parameter  int TURN_CYC    = 4,
    parameter  int HIT_MAX     = 8,
    parameter  int STARVE_MAX  = 32,
    localparam int FIFO_NUM    = RD_FIFO_NUM + WR_FIFO_NUM,
    localparam int BURST       = RA + CA - 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FIFO_NUM-1:0]       empty,
    input  logic [FIFO_NUM-1:0]       full,
    input  logic [FIFO_NUM*BURST-1:0] first_burst,
    input  logic                      ready_i,
    output logic [FIFO_NUM-1:0]       pop,
    output logic                      mode_o,
    output logic                      switch_o,
    output logic                      row_hit_o
);

    localparam int IW = $clog2(FIFO_NUM);
    localparam int HW = $clog2(HIT_MAX + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam logic [HW-1:0]       HIT_LIM    = HW'(HIT_MAX);
    localparam logic [SW-1:0]       STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0]       TURN_LAST  = TW'(TURN_CYC - 1);
    localparam logic [FIFO_NUM-1:0] RD_MASK    = FIFO_NUM'((1 << RD_FIFO_NUM) - 1);
    localparam logic [FIFO_NUM-1:0] WR_MASK    = ~RD_MASK;
    localparam logic [IW-1:0]       RD_LAST    = IW'(RD_FIFO_NUM - 1);
    localparam logic [IW-1:0]       WR_LAST    = IW'(WR_FIFO_NUM - 1);
    localparam logic [IW-1:0]       WR_BASE    = IW'(RD_FIFO_NUM);

    typedef enum logic [1:0] {RD_MODE, WR_MODE, SWITCH} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_target;
    logic            w_nextTarget;
    logic            r_mode;
    logic            r_switch;
    logic [TW-1:0]   r_turnCnt;
    logic [HW-1:0]   r_hitCnt;
    logic [SW-1:0]   r_wrWait;
    logic [SW-1:0]   r_rdWait;
    logic [IW-1:0]   r_rrRd;
    logic [IW-1:0]   r_rrWr;
    logic            r_openRowValid;
    logic [RA-1:0]   r_openRow;

    logic [RA-1:0]       w_row [FIFO_NUM];
    logic [FIFO_NUM-1:0] w_elig;
    logic                w_rdAny, w_wrAny, w_rdFull, w_wrFull;
    logic                w_rdToWr, w_wrToRd, w_inMode;
    logic                w_hitFound, w_rrFound, w_selHit;
    logic [IW-1:0]       w_hitIdx, w_rrIdx, w_selIdx, w_wrLocal;
    logic                w_issueCore, w_issue, w_enterSwitch;
    logic                w_unusedCol;

    for (genvar g = 0; g < FIFO_NUM; g++) begin : g_row
        assign w_row[g] = first_burst[g*BURST + BURST - 1 -: RA];
    end
    assign w_unusedCol = ^first_burst;

    assign w_rdAny  = |(~empty & RD_MASK);
    assign w_wrAny  = |(~empty & WR_MASK);
    assign w_rdFull = |(full & RD_MASK);
    assign w_wrFull = |(full & WR_MASK);
    assign w_elig   = ~empty & ((r_state == WR_MODE) ? WR_MASK : RD_MASK);

    // Write-full pressure always wins over read-full, so a write-full blocks the return to read.
    assign w_rdToWr = w_wrFull || (!w_rdAny && w_wrAny) || ((r_wrWait == STARVE_LIM) && w_wrAny);
    assign w_wrToRd = (!w_wrAny && w_rdAny) ||
                      (!w_wrFull && w_rdAny && ((r_rdWait == STARVE_LIM) || w_rdFull));
    assign w_inMode = ((r_state == RD_MODE) && !w_rdToWr) || ((r_state == WR_MODE) && !w_wrToRd);

    always_comb begin
        w_hitFound = 1'b0;
        w_hitIdx   = '0;
        for (int i = FIFO_NUM - 1; i >= 0; i--) begin
            if (w_elig[i] && (w_row[i] == r_openRow)) begin
                w_hitFound = 1'b1;
                w_hitIdx   = IW'(i);
            end
        end
    end

    // Scan downward so the last match written is the nearest eligible FIFO at or after the pointer.
    always_comb begin : rrSearch
        int base, n, ptr, j;
        base = 0;
        n    = RD_FIFO_NUM;
        ptr  = int'(r_rrRd);
        j    = 0;
        if (r_state == WR_MODE) begin
            base = RD_FIFO_NUM;
            n    = WR_FIFO_NUM;
            ptr  = int'(r_rrWr);
        end
        w_rrFound = 1'b0;
        w_rrIdx   = '0;
        for (int k = FIFO_NUM - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (w_elig[IW'(base + j)]) begin
                    w_rrFound = 1'b1;
                    w_rrIdx   = IW'(base + j);
                end
            end
        end
    end

    assign w_selHit    = r_openRowValid && (r_hitCnt < HIT_LIM) && w_hitFound;
    assign w_selIdx    = w_selHit ? w_hitIdx : w_rrIdx;
    assign w_wrLocal   = w_selIdx - WR_BASE;
    assign w_issueCore = w_inMode && ready_i && w_rrFound;
    assign w_issue     = w_issueCore && rst_n;

    assign pop       = w_issue ? (FIFO_NUM'(1) << w_selIdx) : '0;
    assign row_hit_o = w_issue && w_selHit;
    assign mode_o    = r_mode;
    assign switch_o  = r_switch;

    always_comb begin
        w_nextState  = r_state;
        w_nextTarget = r_target;
        case (r_state)
            RD_MODE: if (w_rdToWr) begin
                w_nextState  = SWITCH;
                w_nextTarget = 1'b0;
            end
            WR_MODE: if (w_wrToRd) begin
                w_nextState  = SWITCH;
                w_nextTarget = 1'b1;
            end
            SWITCH: if (r_turnCnt == TURN_LAST) begin
                w_nextState = r_target ? RD_MODE : WR_MODE;
            end
            default: w_nextState = RD_MODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RD_MODE;
            r_target <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_target <= w_nextTarget;
        end
    end

    assign w_enterSwitch = (r_state != SWITCH) && (w_nextState == SWITCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode         <= 1'b1;
            r_switch       <= 1'b0;
            r_turnCnt      <= '0;
            r_hitCnt       <= '0;
            r_wrWait       <= '0;
            r_rdWait       <= '0;
            r_rrRd         <= '0;
            r_rrWr         <= '0;
            r_openRowValid <= 1'b0;
            r_openRow      <= '0;
        end else begin
            r_switch <= (w_nextState == SWITCH);
            if (w_nextState == RD_MODE) begin
                r_mode <= 1'b1;
            end else if (w_nextState == WR_MODE) begin
                r_mode <= 1'b0;
            end

            if (w_enterSwitch || (r_state != SWITCH)) begin
                r_turnCnt <= '0;
            end else begin
                r_turnCnt <= r_turnCnt + 1'b1;
            end

            if ((w_nextState == WR_MODE) && (r_state != WR_MODE)) begin
                r_wrWait <= '0;
            end else if ((r_state == RD_MODE) && w_wrAny && (r_wrWait != STARVE_LIM)) begin
                r_wrWait <= r_wrWait + 1'b1;
            end
            if ((w_nextState == RD_MODE) && (r_state != RD_MODE)) begin
                r_rdWait <= '0;
            end else if ((r_state == WR_MODE) && w_rdAny && (r_rdWait != STARVE_LIM)) begin
                r_rdWait <= r_rdWait + 1'b1;
            end

            if (w_enterSwitch) begin
                r_openRowValid <= 1'b0;
                r_hitCnt       <= '0;
            end else if (w_issueCore) begin
                r_openRowValid <= 1'b1;
                r_openRow      <= w_row[w_selIdx];
                r_hitCnt       <= w_selHit ? r_hitCnt + 1'b1 : '0;
            end

            // Row hits leave the pointer alone so fairness resumes where it stopped.
            if (w_issueCore && !w_selHit) begin
                if (r_state == RD_MODE) begin
                    r_rrRd <= (w_selIdx == RD_LAST) ? '0 : w_selIdx + 1'b1;
                end else begin
                    r_rrWr <= (w_wrLocal == WR_LAST) ? '0 : w_wrLocal + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cntr_bs_arbiter.sv
// Scoreboard bench for cntr_bs_arbiter: directed scenarios plus random traffic,
// each cycle's expected outputs come from a queue-fed behavioural model.
module tb_cntr_bs_arbiter;

    localparam int RDN    = 4;
    localparam int WRN    = 3;
    localparam int NF     = RDN + WRN;
    localparam int RA     = 16;
    localparam int CA     = 10;
    localparam int BURST  = RA + CA - 4;
    localparam int TURN   = 4;
    localparam int HITMAX = 8;
    localparam int STARVE = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NF-1:0]          empty = '1;
    logic [NF-1:0]          full = '0;
    logic [NF*BURST-1:0]    first_burst = '0;
    logic                   ready_i = 1'b0;
    logic [NF-1:0]          pop;
    logic                   mode_o, switch_o, row_hit_o;

    typedef struct {
        logic [NF-1:0] pop;
        logic          hit;
        logic          mode;
        logic          sw;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   tbRow[NF];

    bit   mRead;
    int   mTurn;
    bit   mOpenValid;
    int   mOpenRow;
    int   mStreak;
    int   mPtr[2];
    int   mWait[2];

    cntr_bs_arbiter #(
        .RD_FIFO_NUM(RDN), .WR_FIFO_NUM(WRN), .RA(RA), .CA(CA),
        .TURN_CYC(TURN), .HIT_MAX(HITMAX), .STARVE_MAX(STARVE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .full(full),
        .first_burst(first_burst), .ready_i(ready_i), .pop(pop),
        .mode_o(mode_o), .switch_o(switch_o), .row_hit_o(row_hit_o)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mRead = 1'b1; mTurn = -1; mOpenValid = 1'b0; mOpenRow = 0; mStreak = 0;
        mPtr[0] = 0; mPtr[1] = 0; mWait[0] = 0; mWait[1] = 0;
    endtask

    // Class 0 = reads, class 1 = writes; mTurn < 0 means not turning around.
    task automatic modelStep(input logic [NF-1:0] emp, input logic [NF-1:0] ful,
                             input logic rdy, output exp_t e);
        bit anyC[2];
        bit fullC[2];
        bit leave;
        int cls, oth, base, n, g, k;
        e.pop = '0; e.hit = 1'b0; e.mode = mRead; e.sw = (mTurn >= 0);
        anyC[0] = 0; anyC[1] = 0; fullC[0] = 0; fullC[1] = 0;
        for (int f = 0; f < NF; f++) begin
            if (!emp[f]) anyC[f < RDN ? 0 : 1] = 1'b1;
            if (ful[f])  fullC[f < RDN ? 0 : 1] = 1'b1;
        end
        if (mTurn >= 0) begin
            if (mTurn == TURN - 1) begin
                mTurn = -1;
                mRead = !mRead;
                mWait[mRead ? 0 : 1] = 0;
            end else begin
                mTurn++;
            end
        end else begin
            cls = mRead ? 0 : 1;
            oth = 1 - cls;
            if (mRead)
                leave = fullC[1] || (!anyC[0] && anyC[1]) || (mWait[1] == STARVE && anyC[1]);
            else
                leave = (!anyC[1] && anyC[0]) ||
                        (!fullC[1] && anyC[0] && (mWait[0] == STARVE || fullC[0]));
            if (anyC[oth] && mWait[oth] < STARVE) mWait[oth]++;
            if (leave) begin
                mTurn = 0; mOpenValid = 1'b0; mStreak = 0;
            end else if (rdy && anyC[cls]) begin
                base = mRead ? 0 : RDN;
                n    = mRead ? RDN : WRN;
                g    = -1;
                if (mOpenValid && mStreak < HITMAX)
                    for (int s = 0; s < n; s++)
                        if (g < 0 && !emp[base + s] && tbRow[base + s] == mOpenRow) g = base + s;
                if (g >= 0) begin
                    e.hit = 1'b1;
                    if (mStreak < HITMAX) mStreak++;
                end else begin
                    for (int s = 0; s < n; s++) begin
                        k = (mPtr[cls] + s) % n;
                        if (g < 0 && !emp[base + k]) g = base + k;
                    end
                    mPtr[cls] = (g - base + 1) % n;
                    mStreak = 0;
                end
                e.pop = NF'(1) << g;
                mOpenRow = tbRow[g];
                mOpenValid = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic [NF-1:0] emp,
                                 input logic [NF-1:0] ful, input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rstIn; empty = emp; full = ful; ready_i = rdy;
        for (int f = 0; f < NF; f++)
            first_burst[f*BURST +: BURST] = {16'(tbRow[f]), 6'($urandom)};
        if (!rstIn) begin
            modelReset();
            e.pop = '0; e.hit = 1'b0; e.mode = 1'b1; e.sw = 1'b0;
        end else begin
            modelStep(emp, ful, rdy, e);
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks += 4;
        if (pop !== e.pop) begin
            errors++;
            $display("[TB] FAIL pop at %0t: got %b expected %b", $time, pop, e.pop);
        end
        if (row_hit_o !== e.hit) begin
            errors++;
            $display("[TB] FAIL row_hit_o at %0t: got %b expected %b", $time, row_hit_o, e.hit);
        end
        if (mode_o !== e.mode) begin
            errors++;
            $display("[TB] FAIL mode_o at %0t: got %b expected %b", $time, mode_o, e.mode);
        end
        if (switch_o !== e.sw) begin
            errors++;
            $display("[TB] FAIL switch_o at %0t: got %b expected %b", $time, switch_o, e.sw);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        int r;
        logic [NF-1:0] emp, ful;
        modelReset();
        for (int f = 0; f < NF; f++) tbRow[f] = 0;

        repeat (3) applyStimulus(1'b0, '1, '0, 1'b1);

        // Single read FIFO, then a row hit from the lowest matching FIFO.
        tbRow[2] = 'h0010;
        applyStimulus(1'b1, 7'b1111011, '0, 1'b1);
        tbRow[0] = 'h0010;
        applyStimulus(1'b1, 7'b1111010, '0, 1'b1);

        // Long hit streak on FIFOs 0,1,3 reaching the cap.
        applyStimulus(1'b0, '1, '0, 1'b1);
        tbRow[0] = 'h0005; tbRow[1] = 'h0005; tbRow[3] = 'h0005;
        repeat (12) applyStimulus(1'b1, 7'b1110100, '0, 1'b1);

        // Write FIFO 5 full forces the turnaround, then write issue.
        tbRow[5] = 'h0123;
        repeat (7) applyStimulus(1'b1, 7'b1011110, 7'b0100000, 1'b1);

        // Both a write and a read full in write mode: stay, then return once write drains.
        tbRow[4] = 'h0777;
        repeat (6) applyStimulus(1'b1, 7'b1101110, 7'b0010001, 1'b1);
        repeat (8) applyStimulus(1'b1, 7'b1101110, 7'b0000001, 1'b1);

        // Write starvation while reads keep flowing.
        applyStimulus(1'b0, '1, '0, 1'b1);
        tbRow[6] = 'h0042;
        repeat (45) applyStimulus(1'b1, 7'b0111110, '0, 1'b1);

        // Reset during turnaround count 2.
        applyStimulus(1'b0, '1, '0, 1'b1);
        repeat (3) applyStimulus(1'b1, 7'b1011110, 7'b0100000, 1'b1);
        applyStimulus(1'b0, 7'b1011110, 7'b0100000, 1'b1);
        repeat (3) applyStimulus(1'b1, 7'b1111110, '0, 1'b1);

        for (int c = 0; c < 1500; c++) begin
            for (int f = 0; f < NF; f++) begin
                r = int'($urandom_range(0, 9));
                tbRow[f] = (r < 6) ? 'h0005 : (r < 8) ? 'h0010 : int'($urandom_range(0, 65535));
            end
            emp = NF'($urandom);
            ful = '0;
            for (int f = 0; f < NF; f++)
                if ($urandom_range(0, 15) == 0) ful[f] = 1'b1;
            emp = emp & ~ful;
            applyStimulus(($urandom_range(0, 299) != 0), emp, ful, ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
